clock_divisor_bank: RTL and testbench
=====================================

CLOCK_DIVISOR_BANK -- requirements
Module: clock_divisor_bank

Interface
REQ-001 Parameter N_CH, default 4: number of independent divider channels (1..16).
REQ-002 Parameter WIDTH, default 27: divisor and counter width in bits (2..32).
REQ-003 Parameter DEF_DIV, default 3: per-channel divisor loaded at reset (period = DEF_DIV+1).
REQ-004 Parameter DEF_EN, default all ones (N_CH bits): per-channel enable loaded at reset.
REQ-005 clk  in  1  sole clock, all state on rising edge.
REQ-006 rst_n  in  1  reset, asynchronous, active-low.
REQ-007 wr_en  in  1  write strobe, one-cycle request.
REQ-008 wr_ch  in  4  target channel index.
REQ-009 wr_div  in  WIDTH  new divisor value D (period D+1 cycles).
REQ-010 wr_ena  in  1  new enable value for the target channel.
REQ-011 sync  in  1  phase-align strobe for all channels.
REQ-012 wr_ack  out  1  one-cycle pulse, write accepted.
REQ-013 wr_err  out  1  one-cycle pulse, write rejected (wr_ch >= N_CH).
REQ-014 tick  out  N_CH  one-cycle pulse per channel at end of each period.
REQ-015 wave  out  N_CH  registered square wave per channel, duty as REQ-021.

Function
REQ-016 Per channel state: active divisor act (WIDTH), pending divisor pend (WIDTH), pend_vld, enable en, counter cnt (WIDTH).
REQ-017 Enabled channel: cnt counts 0..act, then wraps to 0; period exactly act+1 cycles.
REQ-018 tick[i] SHALL be registered, high for the one cycle following the edge where cnt==act, i.e. asserted coincident with cnt==0 after a wrap.
REQ-019 act==0: tick[i] high every cycle while enabled; wave[i] held 0.
REQ-020 Counter arithmetic: no overflow possible, cnt <= act always; act==2^WIDTH-1 allowed.
REQ-021 wave[i] registered; high when cnt <= (act>>1), else low; high time = floor(act/2)+1 cycles per period (50% for even periods, one extra high cycle for odd).
REQ-022 Write with wr_ch < N_CH: wr_div stored to pend, pend_vld set, en updated to wr_ena at the same edge; wr_ack pulses the next cycle.
REQ-023 Write with wr_ch >= N_CH: no state change; wr_err pulses the next cycle; wr_ack stays 0.
REQ-024 pend transfers to act only at a wrap (cnt==act edge) or sync; pend_vld then clears; no period is ever shortened mid-count (glitch-free).
REQ-025 Write to channel in the same cycle as its wrap: new wr_div becomes act at that edge.
REQ-026 Disabled channel: cnt held 0, tick 0, wave 0; pending divisor still accepted.
REQ-027 Enable 0->1: pend (if valid) applied to act, cnt starts at 0 on the next edge; first tick after act+1 cycles.
REQ-028 sync high: every enabled channel loads cnt=0, applies pend if valid, no tick generated by that edge; disabled channels unaffected.
REQ-029 sync and write same cycle: write stored first, then sync applies it (new D active immediately).
REQ-030 Back-to-back writes to one channel before a wrap: last one wins.

Reset
REQ-031 rst_n low asynchronously forces: act=DEF_DIV, pend_vld=0, en=DEF_EN, cnt=0, tick=0, wave=0, wr_ack=0, wr_err=0.
REQ-032 After rst_n release, channel with default settings produces first tick on cycle DEF_DIV+1, then every DEF_DIV+1 cycles.
REQ-033 rst_n asserted mid-period or mid-write discards all pending state; no write acknowledged.

Verification
REQ-034 Reset release, defaults -> every channel: tick every 4 cycles, wave 1100 pattern, all channels in phase.
REQ-035 Write ch1 D=4 at cnt=1 -> wr_ack next cycle; ch1 completes old 4-cycle period, then 5-cycle periods, wave high 3 low 2.
REQ-036 Write wr_ch=N_CH -> wr_err 1 cycle, wr_ack 0, all outputs unchanged.
REQ-037 Ch0 D=2, ch2 D=6, pulse sync -> both cnt=0 next cycle, ticks coincide every 21 cycles.
REQ-038 Write ch3 D=0 en=1 -> tick[3] high continuously after wrap, wave[3]=0; then wr_ena=0 -> tick[3], wave[3] drop to 0 the next cycle.
REQ-039 Assert rst_n mid-period with pend_vld set -> outputs 0 immediately, act=DEF_DIV after release, pending value lost.

Source files
------------

// File: rtl/clock_divisor_bank.sv
// clock_divisor_bank: N_CH programmable clock dividers with
// glitch-free divisor updates and a global phase-align strobe.
module clock_divisor_bank #(
  parameter int               N_CH    = 4,
  parameter int               WIDTH   = 27,
  parameter logic [WIDTH-1:0] DEF_DIV = WIDTH'(3),
  parameter logic [N_CH-1:0]  DEF_EN  = '1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [3:0]       wr_ch,
  input  logic [WIDTH-1:0] wr_div,
  input  logic             wr_ena,
  input  logic             sync,
  output logic             wr_ack,
  output logic             wr_err,
  output logic [N_CH-1:0]  tick,
  output logic [N_CH-1:0]  wave
);

  logic            w_wr_ok;
  logic [N_CH-1:0] w_tick_n;
  logic [N_CH-1:0] w_wave_n;
  logic [N_CH-1:0] r_tick;
  logic [N_CH-1:0] r_wave;
  logic            r_ack;
  logic            r_err;

  assign w_wr_ok = wr_en && ({1'b0, wr_ch} < 5'(N_CH));

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    logic [WIDTH-1:0] r_act;
    logic [WIDTH-1:0] r_pend;
    logic [WIDTH-1:0] r_cnt;
    logic             r_vld;
    logic             r_en;

    logic             w_hit;
    logic             w_en_n;
    logic             w_pv;
    logic [WIDTH-1:0] w_pval;
    logic             w_wrap;
    logic             w_load;
    logic [WIDTH-1:0] w_act_n;
    logic             w_vld_n;
    logic [WIDTH-1:0] w_cnt_n;

    // A write in this cycle is folded in before any load, so a wrap,
    // sync or enable on the same edge picks up the new divisor.
    always_comb begin
      w_hit   = w_wr_ok && (wr_ch == 4'(g));
      w_en_n  = w_hit ? wr_ena : r_en;
      w_pv    = w_hit || r_vld;
      w_pval  = w_hit ? wr_div : r_pend;
      w_wrap  = r_en && (r_cnt == r_act);
      w_load  = w_en_n && (!r_en || sync || w_wrap);
      w_act_n = (w_load && w_pv) ? w_pval : r_act;
      w_vld_n = w_pv && !w_load;
      w_cnt_n = r_cnt + 1'b1;
      if (!w_en_n || w_load) begin
        w_cnt_n = '0;
      end
    end

    assign w_tick_n[g] = w_en_n && w_wrap && !sync;
    assign w_wave_n[g] = w_en_n && (w_act_n != '0) &&
                         (w_cnt_n <= (w_act_n >> 1));

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_act  <= DEF_DIV;
        r_pend <= '0;
        r_vld  <= 1'b0;
        r_en   <= DEF_EN[g];
        r_cnt  <= '0;
      end else begin
        r_act  <= w_act_n;
        r_pend <= w_pval;
        r_vld  <= w_vld_n;
        r_en   <= w_en_n;
        r_cnt  <= w_cnt_n;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tick <= '0;
      r_wave <= '0;
      r_ack  <= 1'b0;
      r_err  <= 1'b0;
    end else begin
      r_tick <= w_tick_n;
      r_wave <= w_wave_n;
      r_ack  <= w_wr_ok;
      r_err  <= wr_en && !w_wr_ok;
    end
  end

  assign tick   = r_tick;
  assign wave   = r_wave;
  assign wr_ack = r_ack;
  assign wr_err = r_err;

endmodule

// File: tb/tb_clock_divisor_bank.sv
// tb_clock_divisor_bank: directed vector table plus hand-written
// sequences for sync, reset and full-range divisor corner cases.
module tb_clock_divisor_bank;

  localparam int N_CH  = 4;
  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             wr_en = 1'b0;
  logic [3:0]       wr_ch = '0;
  logic [WIDTH-1:0] wr_div = '0;
  logic             wr_ena = 1'b0;
  logic             sync = 1'b0;
  logic             wr_ack;
  logic             wr_err;
  logic [N_CH-1:0]  tick;
  logic [N_CH-1:0]  wave;

  int n_run = 0;
  int n_fail = 0;

  clock_divisor_bank #(
    .N_CH(N_CH),
    .WIDTH(WIDTH),
    .DEF_DIV(8'd3),
    .DEF_EN(4'hF)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .wr_en(wr_en),
    .wr_ch(wr_ch),
    .wr_div(wr_div),
    .wr_ena(wr_ena),
    .sync(sync),
    .wr_ack(wr_ack),
    .wr_err(wr_err),
    .tick(tick),
    .wave(wave)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         rst;
    bit         we;
    logic [3:0] ch;
    logic [7:0] dv;
    bit         ena;
    bit         sy;
    logic [3:0] t;
    logic [3:0] w;
    bit         ack;
    bit         err;
  } vec_t;

  vec_t vq[$];

  task automatic add(input bit rst, input bit we, input int ch,
                     input int dv, input bit ena, input bit sy,
                     input logic [3:0] t, input logic [3:0] w,
                     input bit ack, input bit err);
    vec_t v;
    v.rst = rst; v.we = we; v.ch = 4'(ch); v.dv = 8'(dv);
    v.ena = ena; v.sy = sy; v.t = t; v.w = w;
    v.ack = ack; v.err = err;
    vq.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", nm, got, exp);
    end
  endtask

  task automatic idle_in();
    wr_en = 1'b0; wr_ch = '0; wr_div = '0;
    wr_ena = 1'b0; sync = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [9:0] outs();
    return {tick, wave, wr_ack, wr_err};
  endfunction

  task automatic do_reset();
    idle_in();
    rst_n = 1'b0;
    #2;
    chk("reset_outs", 32'(outs()), 32'h0);
    step();
    rst_n = 1'b1;
  endtask

  task automatic wr(input int ch, input int dv, input bit ena);
    wr_en = 1'b1; wr_ch = 4'(ch); wr_div = WIDTH'(dv);
    wr_ena = ena;
  endtask

  initial begin
    // seg A: defaults, ch1 D=4 mid-period, out-of-range write
    add(1,0,0,0,0,0, 4'b0000,4'b1111,0,0);
    add(0,0,0,0,0,0, 4'b0000,4'b0000,0,0);
    add(0,0,0,0,0,0, 4'b0000,4'b0000,0,0);
    add(0,0,0,0,0,0, 4'b1111,4'b1111,0,0);
    add(0,0,0,0,0,0, 4'b0000,4'b1111,0,0);
    add(0,1,1,4,1,0, 4'b0000,4'b0000,1,0);
    add(0,0,0,0,0,0, 4'b0000,4'b0000,0,0);
    add(0,0,0,0,0,0, 4'b1111,4'b1111,0,0);
    add(0,0,0,0,0,0, 4'b0000,4'b1111,0,0);
    add(0,0,0,0,0,0, 4'b0000,4'b0010,0,0);
    add(0,0,0,0,0,0, 4'b0000,4'b0000,0,0);
    add(0,0,0,0,0,0, 4'b1101,4'b1101,0,0);
    add(0,0,0,0,0,0, 4'b0010,4'b1111,0,0);
    add(0,0,0,0,0,0, 4'b0000,4'b0010,0,0);
    add(0,0,0,0,0,0, 4'b0000,4'b0010,0,0);
    add(0,0,0,0,0,0, 4'b1101,4'b1101,0,0);
    add(0,1,4,9,1,0, 4'b0000,4'b1101,0,1);
    add(0,0,0,0,0,0, 4'b0010,4'b0010,0,0);
    // seg B: disabled pend, enable, wrap write, sync+write
    add(1,1,2,1,0,0, 4'b0000,4'b1011,1,0);
    add(0,1,2,7,0,0, 4'b0000,4'b0000,1,0);
    add(0,1,2,2,0,0, 4'b0000,4'b0000,1,0);
    add(0,1,2,1,1,0, 4'b1011,4'b1111,1,0);
    add(0,0,0,0,0,0, 4'b0000,4'b1011,0,0);
    add(0,0,0,0,0,0, 4'b0100,4'b0100,0,0);
    add(0,1,15,3,1,0,4'b0000,4'b0000,0,1);
    add(0,0,0,0,0,0, 4'b1111,4'b1111,0,0);
    add(0,0,0,0,0,0, 4'b0000,4'b1011,0,0);
    add(0,0,0,0,0,0, 4'b0100,4'b0100,0,0);
    add(0,0,0,0,0,0, 4'b0000,4'b0000,0,0);
    add(0,1,0,1,1,0, 4'b1111,4'b1111,1,0);
    add(0,0,0,0,0,0, 4'b0000,4'b1010,0,0);
    add(0,0,0,0,0,0, 4'b0101,4'b0101,0,0);
    add(0,1,1,2,1,1, 4'b0000,4'b1111,1,0);
    add(0,0,0,0,0,0, 4'b0000,4'b1010,0,0);
    add(0,0,0,0,0,0, 4'b0101,4'b0101,0,0);
    add(0,0,0,0,0,0, 4'b0010,4'b0010,0,0);
    // seg C: ch3 D=0 continuous tick, then disable
    add(1,1,3,0,1,0, 4'b0000,4'b1111,1,0);
    add(0,0,0,0,0,0, 4'b0000,4'b0000,0,0);
    add(0,0,0,0,0,0, 4'b0000,4'b0000,0,0);
    add(0,0,0,0,0,0, 4'b1111,4'b0111,0,0);
    add(0,0,0,0,0,0, 4'b1000,4'b0111,0,0);
    add(0,0,0,0,0,0, 4'b1000,4'b0000,0,0);
    add(0,0,0,0,0,0, 4'b1000,4'b0000,0,0);
    add(0,0,0,0,0,0, 4'b1111,4'b0111,0,0);
    add(0,1,3,0,0,0, 4'b0000,4'b0111,1,0);
    add(0,0,0,0,0,0, 4'b0000,4'b0000,0,0);

    for (int i = 0; i < vq.size(); i++) begin
      if (vq[i].rst) do_reset();
      idle_in();
      if (vq[i].we) wr(int'(vq[i].ch), int'(vq[i].dv), vq[i].ena);
      sync = vq[i].sy;
      step();
      idle_in();
      chk($sformatf("vec%0d", i), 32'(outs()),
          32'({vq[i].t, vq[i].w, vq[i].ack, vq[i].err}));
    end

    // ch0 D=2, ch2 D=6, sync: ticks coincide every 21 cycles
    begin
      int hits;
      logic [3:0] et;
      logic [3:0] ew;
      hits = 0;
      do_reset();
      wr(0, 2, 1); step();
      wr(2, 6, 1); step();
      idle_in(); sync = 1'b1; step();
      sync = 1'b0;
      chk("sync_edge", 32'({tick, wave}), 32'({4'h0, 4'hF}));
      for (int k = 1; k <= 42; k++) begin
        step();
        et = {k % 4 == 0, k % 7 == 0, k % 4 == 0, k % 3 == 0};
        ew = {k % 4 <= 1, k % 7 <= 3, k % 4 <= 1, k % 3 <= 1};
        chk($sformatf("sync_k%0d", k), 32'({tick, wave}),
            32'({et, ew}));
        if (tick[0] && tick[2]) hits++;
      end
      chk("sync_coincide", 32'(hits), 32'd2);
    end

    // async reset mid-period and mid-write drops pending state
    begin
      logic [3:0] et;
      logic [3:0] ew;
      do_reset();
      wr(0, 5, 1); step();
      idle_in();
      chk("rst_pre_ack", 32'(wr_ack), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("rst_async", 32'(outs()), 32'h0);
      wr(1, 6, 1); step();
      chk("rst_mid_wr", 32'(outs()), 32'h0);
      idle_in();
      rst_n = 1'b1;
      for (int k = 1; k <= 12; k++) begin
        step();
        et = (k % 4 == 0) ? 4'hF : 4'h0;
        ew = (k % 4 <= 1) ? 4'hF : 4'h0;
        chk($sformatf("rst_k%0d", k), 32'(outs()),
            32'({et, ew, 2'b00}));
      end
    end

    // full-range divisor 2^WIDTH-1 on ch0
    begin
      do_reset();
      wr(0, 255, 1); step();
      idle_in();
      step(); step(); step();
      chk("max_load", 32'({tick[0], wave[0]}), 32'b11);
      for (int k = 1; k <= 256; k++) begin
        step();
        chk($sformatf("max_k%0d", k), 32'({tick[0], wave[0]}),
            32'({k == 256, (k % 256) <= 127}));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
